// File: rtl/alu_flag_queue_if.sv
// Bus bundle between the ALU/control side and the alu_flag_queue flag staging block.
interface alu_flag_queue_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             sync;
    logic [WIDTH-1:0] flagi;
    logic             we;
    logic [WIDTH-1:0] wmask;
    logic             flush;
    logic [WIDTH-1:0] flago;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;

    modport master (
        output sync, flagi, we, wmask, flush,
        input  flago, count, empty, full, ovf
    );

    modport slave (
        input  sync, flagi, we, wmask, flush,
        output flago, count, empty, full, ovf
    );
endinterface

// File: rtl/alu_flag_queue.sv
// alu_flag_queue: stages ALU flag snapshots in a circular buffer and commits the
// oldest one into the architectural flag register under a per-bit mask.
// Optional feature macro: ALU_FLAG_BYPASS_EN (empty-queue sync+we commits flagi directly).
module alu_flag_queue #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    alu_flag_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] flago_q, flago_d;
    logic             ovf_q, ovf_d;

    logic empty, full, pop, push, drop, bypass;
    logic [WIDTH-1:0] head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem[rptr_q];

`ifdef ALU_FLAG_BYPASS_EN
    assign bypass = !bus.flush && empty && bus.sync && bus.we;
`else
    assign bypass = 1'b0;
`endif

    // A pop frees the head slot, so a push into a full queue is legal alongside it.
    assign pop  = !bus.flush && bus.we && !empty;
    assign push = !bus.flush && bus.sync && (!full || pop) && !bypass;
    assign drop = !bus.flush && bus.sync && full && !pop;

    // Next-state for occupancy, sticky overflow and the architectural flags.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        flago_d = flago_q;
        if (bus.flush) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) ovf_d = 1'b1;
            if (pop) begin
                flago_d = (flago_q & ~bus.wmask) | (head & bus.wmask);
            end else if (bypass) begin
                flago_d = (flago_q & ~bus.wmask) | (bus.flagi & bus.wmask);
            end
        end
    end

    // Registered pointers, occupancy, overflow and flags with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            flago_q <= '0;
        end else begin
            if (bus.flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (pop)  rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            flago_q <= flago_d;
        end
    end

    // Snapshot storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= bus.flagi;
    end

    assign bus.flago = flago_q;
    assign bus.count = count_q;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.ovf   = ovf_q;
endmodule
